// File: rtl/uarc_send_receiver_if.sv
// Bundle of the receiver-side bus links and the core message port of uarc_send_receiver.
// slave is the receiver block's view; master is the view of the senders plus core.
//
// Handshakes:
//   receiver_sends[i] is a level request that the sender holds until it sees
//   receiver_send_acks[i] high for one cycle. int_valid/int_ready: a transfer
//   happens on a rising edge where both are 1; int_* are stable while int_valid is high.
interface uarc_send_receiver_if #(
    parameter int WORD_MAG    = 5,
    parameter int TOTAL_BUSES = 4
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;

    logic [TOTAL_BUSES-1:0]                 receiver_enable;
    logic [TOTAL_BUSES-1:0]                 receiver_sends;
    logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_permissions;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_self_addresses;
    logic                                   interrupt_enable;
    logic                                   int_valid;
    logic                                   int_ready;
    logic [WORD_WIDTH-1:0]                  int_bus;
    logic [WORD_WIDTH-1:0]                  int_data;
    logic [WORD_WIDTH-1:0]                  int_permission;
    logic [WORD_WIDTH-1:0]                  int_address;

    modport slave (
        input  receiver_enable,
        input  receiver_sends,
        input  receiver_datas,
        input  receiver_self_permissions,
        input  receiver_self_addresses,
        input  interrupt_enable,
        input  int_ready,
        output receiver_send_acks,
        output int_valid,
        output int_bus,
        output int_data,
        output int_permission,
        output int_address
    );

    modport master (
        output receiver_enable,
        output receiver_sends,
        output receiver_datas,
        output receiver_self_permissions,
        output receiver_self_addresses,
        output interrupt_enable,
        output int_ready,
        input  receiver_send_acks,
        input  int_valid,
        input  int_bus,
        input  int_data,
        input  int_permission,
        input  int_address
    );
endinterface

// File: rtl/uarc_send_receiver.sv
// Fixed-priority receiver: captures one message from the lowest eligible bus, presents it
// to the core, and acknowledges the sender once the core has taken it.
module uarc_send_receiver #(
    parameter int WORD_MAG    = 5,
    parameter int TOTAL_BUSES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    uarc_send_receiver_if.slave      rx,
    output logic [1:0]               dbg_state
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;
    localparam int BUS_W      = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [TOTAL_BUSES-1:0] ack_done_q, ack_done_d;
    logic [TOTAL_BUSES-1:0] ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic [BUS_W-1:0]       bus_q, bus_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [WORD_WIDTH-1:0]  perm_q, perm_d;
    logic [WORD_WIDTH-1:0]  addr_q, addr_d;

    logic [TOTAL_BUSES-1:0] eligible;
    logic                   sel_found;
    logic [BUS_W-1:0]       sel_idx;
    logic                   hold_live;
    logic [WORD_WIDTH-1:0]  int_bus_w;

    // ack_done masks a request that was already served but is still held high.
    assign eligible  = rx.receiver_enable & rx.receiver_sends & ~ack_done_q;
    assign hold_live = rx.receiver_sends[bus_q] & rx.receiver_enable[bus_q];

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = BUS_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        ack_d      = '0;
        ack_done_d = ack_done_q;
        bus_d      = bus_q;
        data_d     = data_q;
        perm_d     = perm_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (rx.interrupt_enable && sel_found) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    bus_d   = sel_idx;
                    data_d  = rx.receiver_datas[sel_idx];
                    perm_d  = rx.receiver_self_permissions[sel_idx];
                    addr_d  = rx.receiver_self_addresses[sel_idx];
                end
            end
            HOLD: begin
                // A transfer wins over a simultaneous withdrawal.
                if (rx.int_ready) begin
                    state_d       = ACK;
                    ack_d[bus_q]  = 1'b1;
                end else if (!hold_live) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ACK: begin
                state_d           = IDLE;
                ack_done_d[bus_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Dropping the request always re-arms the bus, even on the edge it would be marked.
        ack_done_d = ack_done_d & rx.receiver_sends;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ack_done_q <= '0;
            ack_q      <= '0;
            valid_q    <= 1'b0;
            bus_q      <= '0;
            data_q     <= '0;
            perm_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            ack_done_q <= ack_done_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            bus_q      <= bus_d;
            data_q     <= data_d;
            perm_q     <= perm_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        int_bus_w              = '0;
        int_bus_w[BUS_W-1:0]   = bus_q;
    end

    assign rx.receiver_send_acks = ack_q;
    assign rx.int_valid          = valid_q;
    assign rx.int_bus            = int_bus_w;
    assign rx.int_data           = data_q;
    assign rx.int_permission     = perm_q;
    assign rx.int_address        = addr_q;
    assign dbg_state             = state_q;
endmodule

// File: tb/tb_uarc_send_receiver.sv
// Bench for uarc_send_receiver: directed scenarios with literal expectations, then
// randomized senders/core checked every cycle against a transaction-level model.
module tb_uarc_send_receiver;
    localparam int WORD_MAG = 5;
    localparam int NB       = 4;
    localparam int WW       = 1 << WORD_MAG;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    uarc_send_receiver_if #(.WORD_MAG(WORD_MAG), .TOTAL_BUSES(NB)) bus_if ();

    uarc_send_receiver #(.WORD_MAG(WORD_MAG), .TOTAL_BUSES(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (bus_if),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] oh(input int i);
        return 64'(1) << i;
    endfunction

    // Transaction-level model: which message is presented, which bus is being acked,
    // and which buses have already been served while still holding their request.
    bit              m_hold    = 1'b0;
    int              m_bus     = 0;
    int              m_ack_bus = -1;
    logic [WW-1:0]   m_data    = '0;
    logic [WW-1:0]   m_perm    = '0;
    logic [WW-1:0]   m_addr    = '0;
    logic [NB-1:0]   m_served  = '0;
    logic [WW-1:0]   exp_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hold = 1'b0; m_bus = 0; m_ack_bus = -1;
            m_data = '0; m_perm = '0; m_addr = '0; m_served = '0;
            exp_q.delete();
        end else begin
            int            pick;
            logic [NB-1:0] srv;
            pick = -1;
            for (int i = 0; i < NB; i++)
                if (pick < 0 && bus_if.receiver_enable[i] && bus_if.receiver_sends[i] && !m_served[i])
                    pick = i;
            srv = m_served;
            if (m_ack_bus >= 0) srv[m_ack_bus] = 1'b1;
            srv = srv & bus_if.receiver_sends;
            if (m_ack_bus >= 0) begin
                m_ack_bus = -1;
            end else if (m_hold) begin
                if (bus_if.int_ready) begin
                    m_ack_bus = m_bus;
                    m_hold    = 1'b0;
                    exp_q.push_back(m_data);
                end else if (!(bus_if.receiver_sends[m_bus] && bus_if.receiver_enable[m_bus])) begin
                    m_hold = 1'b0;
                end
            end else if (bus_if.interrupt_enable && pick >= 0) begin
                m_hold = 1'b1;
                m_bus  = pick;
                m_data = bus_if.receiver_datas[pick];
                m_perm = bus_if.receiver_self_permissions[pick];
                m_addr = bus_if.receiver_self_addresses[pick];
            end
            m_served = srv;
        end
    end

    always @(negedge clk) begin
        logic [NB-1:0] ea;
        ea = '0;
        if (m_ack_bus >= 0) ea[m_ack_bus] = 1'b1;
        check("model_valid", 64'(bus_if.int_valid), 64'(m_hold));
        check("model_ack", 64'(bus_if.receiver_send_acks), 64'(ea));
        check("model_bus", 64'(bus_if.int_bus), 64'(m_bus));
        check("model_data", 64'(bus_if.int_data), 64'(m_data));
        check("model_perm", 64'(bus_if.int_permission), 64'(m_perm));
        check("model_addr", 64'(bus_if.int_address), 64'(m_addr));
        if (bus_if.receiver_send_acks != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ack: got ack %b expected no ack at %0t",
                         bus_if.receiver_send_acks, $time);
            end else begin
                check("sb_data", 64'(bus_if.int_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_msg(input int i, input logic [WW-1:0] d);
        bus_if.receiver_datas[i]            = d;
        bus_if.receiver_self_permissions[i] = d ^ 32'h0F0F_0F0F;
        bus_if.receiver_self_addresses[i]   = d + 32'h100;
    endtask

    bit acked [NB];
    int linger[NB];

    initial begin
        logic [WW-1:0] held;
        bus_if.receiver_enable           = '0;
        bus_if.receiver_sends            = '0;
        bus_if.receiver_datas            = '0;
        bus_if.receiver_self_permissions = '0;
        bus_if.receiver_self_addresses   = '0;
        bus_if.interrupt_enable          = 1'b0;
        bus_if.int_ready                 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus_if.int_valid), 64'(0));
        check("rst_ack", 64'(bus_if.receiver_send_acks), 64'(0));
        check("rst_data", 64'(bus_if.int_data), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        #1 reset = 1'b1;
        bus_if.receiver_enable  = '1;
        bus_if.interrupt_enable = 1'b1;
        @(negedge clk); #1;

        // Single send on bus 2, core always ready; request held 3 cycles after ack.
        set_msg(2, 32'hDEAD_BEEF);
        bus_if.int_ready         = 1'b1;
        bus_if.receiver_sends[2] = 1'b1;
        @(negedge clk);
        check("single_valid", 64'(bus_if.int_valid), 64'(1));
        check("single_bus", 64'(bus_if.int_bus), 64'(2));
        check("single_data", 64'(bus_if.int_data), 64'(32'hDEAD_BEEF));
        @(negedge clk);
        check("single_ack", 64'(bus_if.receiver_send_acks), oh(2));
        check("single_valid_off", 64'(bus_if.int_valid), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("single_no_recapture", 64'(bus_if.int_valid), 64'(0));
            check("single_no_reack", 64'(bus_if.receiver_send_acks), 64'(0));
        end
        #1 bus_if.receiver_sends[2] = 1'b0;
        @(negedge clk); #1;

        // Buses 1 and 3 together: bus 1 first, bus 3 three cycles later.
        set_msg(1, 32'h1111_1111);
        set_msg(3, 32'h3333_3333);
        bus_if.receiver_sends = 4'b1010;
        @(negedge clk);
        check("prio_first_bus", 64'(bus_if.int_bus), 64'(1));
        check("prio_first_valid", 64'(bus_if.int_valid), 64'(1));
        @(negedge clk);
        check("prio_ack1", 64'(bus_if.receiver_send_acks), oh(1));
        #1 bus_if.receiver_sends[1] = 1'b0;
        @(negedge clk);
        check("prio_gap_valid", 64'(bus_if.int_valid), 64'(0));
        @(negedge clk);
        check("prio_second_bus", 64'(bus_if.int_bus), 64'(3));
        check("prio_second_data", 64'(bus_if.int_data), 64'(32'h3333_3333));
        @(negedge clk);
        check("prio_ack3", 64'(bus_if.receiver_send_acks), oh(3));
        #1 bus_if.receiver_sends[3] = 1'b0;
        @(negedge clk);
        check("prio_quiet", 64'(bus_if.receiver_send_acks), 64'(0));

        // Backpressure: core not ready for 10 cycles.
        #1 bus_if.int_ready = 1'b0;
        set_msg(0, 32'hA5A5_0000);
        bus_if.receiver_sends[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus_if.int_valid), 64'(1));
            check("bp_data", 64'(bus_if.int_data), 64'(32'hA5A5_0000));
            check("bp_no_ack", 64'(bus_if.receiver_send_acks), 64'(0));
        end
        #1 bus_if.int_ready = 1'b1;
        @(negedge clk);
        check("bp_ack", 64'(bus_if.receiver_send_acks), oh(0));
        #1 bus_if.receiver_sends[0] = 1'b0;
        bus_if.int_ready = 1'b0;
        @(negedge clk); #1;

        // Withdrawal without ready, then withdrawal together with ready.
        set_msg(0, 32'h0000_5A5A);
        bus_if.receiver_sends[0] = 1'b1;
        @(negedge clk);
        check("wd_valid", 64'(bus_if.int_valid), 64'(1));
        #1 bus_if.receiver_sends[0] = 1'b0;
        @(negedge clk);
        check("wd_valid_drop", 64'(bus_if.int_valid), 64'(0));
        check("wd_no_ack", 64'(bus_if.receiver_send_acks), 64'(0));
        @(negedge clk);
        check("wd_no_late_ack", 64'(bus_if.receiver_send_acks), 64'(0));
        #1 bus_if.receiver_sends[0] = 1'b1;
        @(negedge clk);
        check("wd2_valid", 64'(bus_if.int_valid), 64'(1));
        #1 bus_if.receiver_sends[0] = 1'b0;
        bus_if.int_ready = 1'b1;
        @(negedge clk);
        check("wd2_ack", 64'(bus_if.receiver_send_acks), oh(0));
        @(negedge clk); #1;

        // Interrupt gating and link-enable gating.
        bus_if.interrupt_enable  = 1'b0;
        bus_if.receiver_sends[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("gate_ie_valid", 64'(bus_if.int_valid), 64'(0));
        end
        #1 bus_if.interrupt_enable = 1'b1;
        @(negedge clk);
        check("gate_ie_capture", 64'(bus_if.int_valid), 64'(1));
        @(negedge clk);
        check("gate_ie_ack", 64'(bus_if.receiver_send_acks), oh(0));
        #1 bus_if.receiver_sends[0] = 1'b0;
        @(negedge clk); #1;
        bus_if.receiver_enable[0] = 1'b0;
        bus_if.receiver_sends[0]  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("gate_en_valid", 64'(bus_if.int_valid), 64'(0));
        end
        #1 bus_if.receiver_sends[0] = 1'b0;
        bus_if.receiver_enable[0] = 1'b1;
        @(negedge clk); #1;

        // Reset in the middle of HOLD, request still held across it.
        bus_if.int_ready = 1'b0;
        set_msg(0, 32'hCAFE_F00D);
        bus_if.receiver_sends[0] = 1'b1;
        @(negedge clk);
        check("rh_valid", 64'(bus_if.int_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("rh_async_valid", 64'(bus_if.int_valid), 64'(0));
        check("rh_async_data", 64'(bus_if.int_data), 64'(0));
        check("rh_async_state", 64'(dbg_state), 64'(0));
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        bus_if.int_ready = 1'b1;
        @(negedge clk);
        check("rh_recapture", 64'(bus_if.int_valid), 64'(1));
        check("rh_recapture_data", 64'(bus_if.int_data), 64'(32'hCAFE_F00D));
        @(negedge clk);
        check("rh_ack", 64'(bus_if.receiver_send_acks), oh(0));
        #1 bus_if.receiver_sends[0] = 1'b0;
        @(negedge clk);
        check("rh_single_ack", 64'(bus_if.receiver_send_acks), 64'(0));

        // Randomized traffic.
        for (int i = 0; i < NB; i++) begin
            acked[i]  = 1'b0;
            linger[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk); #1;
            for (int i = 0; i < NB; i++) begin
                if (bus_if.receiver_sends[i]) begin
                    if (bus_if.receiver_send_acks[i]) acked[i] = 1'b1;
                    if (acked[i]) begin
                        if (linger[i] == 0) begin
                            bus_if.receiver_sends[i] = 1'b0;
                            acked[i] = 1'b0;
                        end else begin
                            linger[i]--;
                        end
                    end else if ($urandom_range(0, 59) == 0) begin
                        bus_if.receiver_sends[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    held = $urandom();
                    set_msg(i, held);
                    linger[i] = $urandom_range(0, 3);
                    bus_if.receiver_sends[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 49) == 0)
                bus_if.receiver_enable[$urandom_range(0, NB - 1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0)
                bus_if.interrupt_enable = ~bus_if.interrupt_enable;
            bus_if.int_ready = ($urandom_range(0, 2) != 0);
        end
        #1 bus_if.receiver_sends = '0;
        bus_if.int_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uarc_send_receiver.md
UARC_SEND_RECEIVER -- requirements
Module: uarc_send_receiver

Interface
REQ-001 The block SHALL have parameter WORD_MAG, default 5, giving log2 of the word width; WORD_WIDTH = 1 << WORD_MAG.
REQ-002 The block SHALL have parameter TOTAL_BUSES, default 4, giving the number of receiver buses; 1 <= TOTAL_BUSES <= WORD_WIDTH.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous reset, asserted when 0.
REQ-006 receiver_enable  input  TOTAL_BUSES  per-bus link enable.
REQ-007 receiver_sends  input  TOTAL_BUSES  per-bus send request, level, held by sender until acked.
REQ-008 receiver_send_acks  output  TOTAL_BUSES  per-bus one-cycle send acknowledge.
REQ-009 receiver_datas  input  TOTAL_BUSES x WORD_WIDTH  per-bus message word.
REQ-010 receiver_self_permissions  input  TOTAL_BUSES x WORD_WIDTH  per-bus sender permission.
REQ-011 receiver_self_addresses  input  TOTAL_BUSES x WORD_WIDTH  per-bus sender address.
REQ-012 interrupt_enable  input  1  core interrupt bit; gates new captures only.
REQ-013 int_valid  output  1  captured message presented to core.
REQ-014 int_ready  input  1  core accepts message.
REQ-015 int_bus  output  WORD_WIDTH  index of source bus, zero-extended.
REQ-016 int_data, int_permission, int_address  output  WORD_WIDTH each  captured word, permission, address.

Function
REQ-017 eligible[i] SHALL be receiver_enable[i] & receiver_sends[i] & ~ack_done[i].
REQ-018 Selection SHALL pick the lowest-index eligible bus (fixed priority).
REQ-019 The FSM SHALL have exactly three states: IDLE, HOLD and ACK.
REQ-020 IDLE: if interrupt_enable=1 and any eligible bus exists, the FSM SHALL register the bus index, data, permission and address of the selected bus, then go to HOLD; otherwise it SHALL stay in IDLE.
REQ-021 HOLD: int_valid SHALL be 1 and the int_* outputs SHALL be stable register values.
REQ-022 HOLD: int_valid=1 and int_ready=1 at a clock edge is a transfer; the FSM SHALL then go to ACK.
REQ-023 HOLD, captured bus: if receiver_sends or receiver_enable deasserts with int_ready=0, this is a withdrawal; the FSM SHALL return to IDLE with no ack, and int_valid SHALL be 0 next cycle.
REQ-024 A transfer and a withdrawal at the same edge SHALL resolve as a transfer (ACK issued).
REQ-025 ACK: receiver_send_acks[captured bus] SHALL be 1 for exactly one cycle, all other ack bits 0, int_valid 0; ack_done[captured bus] SHALL be set; next state IDLE.
REQ-026 ack_done[i] SHALL clear on any edge where receiver_sends[i]=0, preventing double capture of a held request.
REQ-027 interrupt_enable falling while in HOLD SHALL NOT retract int_valid.
REQ-028 Latency: request eligible at edge N -> int_valid=1 from cycle N+1; transfer at edge M -> ack during cycle M+1; earliest next capture at edge M+2 (minimum 3 cycles per message).
REQ-029 Requests on non-selected buses SHALL stay pending, unacked, with no loss.
REQ-030 int_bus SHALL equal the selected index with upper bits 0.

Reset
REQ-031 While reset=0: state IDLE, ack_done all 0, int_valid 0, receiver_send_acks all 0, int_bus/int_data/int_permission/int_address all 0, asynchronously.
REQ-032 Reset asserted mid-HOLD or mid-ACK SHALL drop int_valid/ack immediately; the pending sender stays unacked and is re-captured after reset release.

Verification
REQ-033 Single send: bus 2 enable=1, send=1, data=0xDEADBEEF, interrupt_enable=1, int_ready tied 1 -> int_valid cycle N+1, int_bus=2, int_data=0xDEADBEEF, ack[2]=1 cycle N+2 only; send held 3 more cycles -> no second capture.
REQ-034 Priority: buses 1 and 3 send simultaneously -> bus 1 served first; bus 3 int_valid no earlier than 3 cycles later; both acked exactly once.
REQ-035 Backpressure: int_ready=0 for 10 cycles while bus 0 sends -> int_valid high and int_* stable all 10 cycles, no ack until the cycle after int_ready=1.
REQ-036 Withdrawal: bus 0 in HOLD, send drops with int_ready=0 -> int_valid 0 next cycle, no ack; same drop together with int_ready=1 -> ack[0] issued.
REQ-037 Gating: interrupt_enable=0 with bus 0 sending -> no capture for 20 cycles; enable=1 -> capture next edge; receiver_enable[0]=0 -> never captured.
REQ-038 Reset mid-HOLD: reset=0 for 2 cycles -> outputs 0 asynchronously; release with send still high -> re-captured, acked once.
